// File: rtl/kvs_shadow_checker.sv
// Shadow scoreboard for a kvs instance: tracks up to NUM_TRACK programmable keys,
// predicts each lookup result and flags data mismatches and protocol violations.
module kvs_shadow_checker #(
  parameter int NUM_KEY_BITS = 8,
  parameter int NUM_VAL_BITS = 8,
  parameter int NUM_PIPES    = 2,
  parameter int NUM_TRACK    = 4,
  parameter int CNT_BITS     = 16,
  localparam int IDX_W       = (NUM_TRACK > 1) ? $clog2(NUM_TRACK) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_idx,
  input  logic [NUM_KEY_BITS-1:0] cfg_key,
  input  logic                    busy,
  input  logic                    insert,
  input  logic [NUM_KEY_BITS-1:0] ins_key,
  input  logic [NUM_VAL_BITS-1:0] ins_value,
  input  logic                    lookup,
  input  logic [NUM_KEY_BITS-1:0] key,
  input  logic                    modify,
  input  logic                    del,
  input  logic [NUM_VAL_BITS-1:0] mod_value,
  input  logic                    valid,
  input  logic [NUM_VAL_BITS-1:0] value,
  output logic                    mismatch,
  output logic                    proto_err,
  output logic                    err_sticky,
  output logic [NUM_KEY_BITS-1:0] first_err_key,
  output logic [CNT_BITS-1:0]     mism_count,
  output logic [CNT_BITS-1:0]     proto_count,
  output logic [CNT_BITS-1:0]     check_count
);

  logic [NUM_KEY_BITS-1:0] trk_key_q [NUM_TRACK];
  logic [NUM_KEY_BITS-1:0] trk_key_d [NUM_TRACK];
  logic [NUM_TRACK-1:0]    trk_en_q, trk_en_d;
  logic [NUM_PIPES:0]      sv_q [NUM_TRACK];
  logic [NUM_PIPES:0]      sv_d [NUM_TRACK];
  logic [NUM_VAL_BITS-1:0] sd_q [NUM_TRACK][NUM_PIPES+1];
  logic [NUM_VAL_BITS-1:0] sd_d [NUM_TRACK][NUM_PIPES+1];
  logic [NUM_PIPES-1:0]    lp_any_q, lp_any_d, lp_hit_q, lp_hit_d;
  logic [IDX_W-1:0]        lp_slot_q [NUM_PIPES];
  logic [IDX_W-1:0]        lp_slot_d [NUM_PIPES];
  logic                    mismatch_q, mismatch_d, proto_err_q, proto_err_d;
  logic                    err_sticky_q, err_sticky_d;
  logic [NUM_KEY_BITS-1:0] first_err_key_q, first_err_key_d;
  logic [CNT_BITS-1:0]     mism_count_q, mism_count_d;
  logic [CNT_BITS-1:0]     proto_count_q, proto_count_d;
  logic [CNT_BITS-1:0]     check_count_q, check_count_d;

  logic                    lk_hit, ins_hit;
  logic [IDX_W-1:0]        lk_slot, ins_slot;
  logic                    cfg_ok, ins_acc, dup_ins, orphan_mod, mism;
  logic [IDX_W-1:0]        chk_slot;
  logic                    chk_sv;
  logic [NUM_VAL_BITS-1:0] chk_sd;

  assign cfg_ok     = cfg_we && (int'(cfg_idx) < NUM_TRACK);
  assign ins_acc    = insert && !busy;
  assign chk_slot   = lp_slot_q[0];
  assign chk_sv     = sv_q[chk_slot][0];
  assign chk_sd     = sd_q[chk_slot][0];
  assign mism       = lp_hit_q[0] && ((valid != chk_sv) || (valid && chk_sv && (value != chk_sd)));
  assign dup_ins    = ins_acc && ins_hit && sv_q[ins_slot][NUM_PIPES];
  assign orphan_mod = modify && !lp_any_q[0];

  // Scanning downwards lets the lowest-index matching slot win.
  always_comb begin
    lk_hit   = 1'b0;
    lk_slot  = '0;
    ins_hit  = 1'b0;
    ins_slot = '0;
    for (int s = NUM_TRACK - 1; s >= 0; s--) begin
      if (trk_en_q[s] && (trk_key_q[s] == key)) begin
        lk_hit  = 1'b1;
        lk_slot = IDX_W'(s);
      end
      if (trk_en_q[s] && (trk_key_q[s] == ins_key)) begin
        ins_hit  = 1'b1;
        ins_slot = IDX_W'(s);
      end
    end
  end

  always_comb begin
    // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
    trk_key_d       = trk_key_q;
    trk_en_d        = trk_en_q;
    sd_d            = sd_q;
    first_err_key_d = first_err_key_q;
    mism_count_d    = mism_count_q;
    proto_count_d   = proto_count_q;
    check_count_d   = check_count_q;

    for (int s = 0; s < NUM_TRACK; s++) begin
      sv_d[s] = {sv_q[s][NUM_PIPES], sv_q[s][NUM_PIPES:1]};
      for (int i = 0; i < NUM_PIPES; i++) sd_d[s][i] = sd_q[s][i+1];
    end

    if (ins_acc && ins_hit && !dup_ins) begin
      sv_d[ins_slot][NUM_PIPES] = 1'b1;
      sd_d[ins_slot][NUM_PIPES] = ins_value;
    end

    // A modify rewrites the whole slot history so in-flight lookups see the new state.
    if (modify && lp_hit_q[0]) begin
      sv_d[chk_slot] = {(NUM_PIPES+1){!del}};
      for (int i = 0; i <= NUM_PIPES; i++) sd_d[chk_slot][i] = mod_value;
    end

    for (int i = 0; i < NUM_PIPES - 1; i++) begin
      lp_any_d[i]  = lp_any_q[i+1];
      lp_hit_d[i]  = lp_hit_q[i+1];
      lp_slot_d[i] = lp_slot_q[i+1];
    end
    lp_any_d[NUM_PIPES-1]  = lookup;
    lp_hit_d[NUM_PIPES-1]  = lookup && lk_hit;
    lp_slot_d[NUM_PIPES-1] = lk_slot;

    if (cfg_ok) begin
      trk_key_d[cfg_idx] = cfg_key;
      trk_en_d[cfg_idx]  = 1'b1;
      sv_d[cfg_idx]      = '0;
      for (int i = 0; i <= NUM_PIPES; i++) sd_d[cfg_idx][i] = '0;
      for (int i = 0; i < NUM_PIPES; i++) if (lp_slot_d[i] == cfg_idx) lp_hit_d[i] = 1'b0;
    end

    mismatch_d   = mism;
    proto_err_d  = dup_ins || orphan_mod;
    err_sticky_d = err_sticky_q || mism || proto_err_d;
    if (!err_sticky_q && (mism || proto_err_d))
      first_err_key_d = mism ? trk_key_q[chk_slot] : (dup_ins ? ins_key : '0);

    if (mism && !(&mism_count_q))          mism_count_d  = mism_count_q + CNT_BITS'(1);
    if (proto_err_d && !(&proto_count_q))  proto_count_d = proto_count_q + CNT_BITS'(1);
    if (lp_hit_q[0] && !(&check_count_q))  check_count_d = check_count_q + CNT_BITS'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shadow arrays are flops, not RAM, so they are reset like any other state.
      for (int s = 0; s < NUM_TRACK; s++) begin
        trk_key_q[s] <= '0;
        sv_q[s]      <= '0;
        for (int i = 0; i <= NUM_PIPES; i++) sd_q[s][i] <= '0;
      end
      for (int i = 0; i < NUM_PIPES; i++) lp_slot_q[i] <= '0;
      trk_en_q        <= '0;
      lp_any_q        <= '0;
      lp_hit_q        <= '0;
      mismatch_q      <= 1'b0;
      proto_err_q     <= 1'b0;
      err_sticky_q    <= 1'b0;
      first_err_key_q <= '0;
      mism_count_q    <= '0;
      proto_count_q   <= '0;
      check_count_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      trk_key_q       <= trk_key_d;
      trk_en_q        <= trk_en_d;
      sv_q            <= sv_d;
      sd_q            <= sd_d;
      lp_any_q        <= lp_any_d;
      lp_hit_q        <= lp_hit_d;
      lp_slot_q       <= lp_slot_d;
      mismatch_q      <= mismatch_d;
      proto_err_q     <= proto_err_d;
      err_sticky_q    <= err_sticky_d;
      first_err_key_q <= first_err_key_d;
      mism_count_q    <= mism_count_d;
      proto_count_q   <= proto_count_d;
      check_count_q   <= check_count_d;
    end
  end

  assign mismatch      = mismatch_q;
  assign proto_err     = proto_err_q;
  assign err_sticky    = err_sticky_q;
  assign first_err_key = first_err_key_q;
  assign mism_count    = mism_count_q;
  assign proto_count   = proto_count_q;
  assign check_count   = check_count_q;

endmodule

// File: tb/tb_kvs_shadow_checker.sv
// Directed bench for kvs_shadow_checker (NUM_PIPES=2, NUM_TRACK=4, 8-bit counters).
module tb_kvs_shadow_checker;

  localparam int KB = 8;
  localparam int VB = 8;
  localparam int NP = 2;
  localparam int NT = 4;
  localparam int CB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [1:0]    cfg_idx;
  logic [KB-1:0] cfg_key;
  logic          busy, insert, lookup, modify, del, valid;
  logic [KB-1:0] ins_key, key;
  logic [VB-1:0] ins_value, mod_value, value;
  logic          mismatch, proto_err, err_sticky;
  logic [KB-1:0] first_err_key;
  logic [CB-1:0] mism_count, proto_count, check_count;

  int n_checks = 0;
  int n_fails  = 0;

  kvs_shadow_checker #(
    .NUM_KEY_BITS(KB), .NUM_VAL_BITS(VB), .NUM_PIPES(NP), .NUM_TRACK(NT), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
    .busy(busy), .insert(insert), .ins_key(ins_key), .ins_value(ins_value),
    .lookup(lookup), .key(key), .modify(modify), .del(del), .mod_value(mod_value),
    .valid(valid), .value(value), .mismatch(mismatch), .proto_err(proto_err),
    .err_sticky(err_sticky), .first_err_key(first_err_key), .mism_count(mism_count),
    .proto_count(proto_count), .check_count(check_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    cfg_we = 0; cfg_idx = 0; cfg_key = 0; busy = 0; insert = 0; ins_key = 0;
    ins_value = 0; lookup = 0; key = 0; modify = 0; del = 0; mod_value = 0;
    valid = 0; value = 0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_mismatch"},   32'(mismatch), 0);
    check({pfx, "_proto_err"},  32'(proto_err), 0);
    check({pfx, "_sticky"},     32'(err_sticky), 0);
    check({pfx, "_first_key"},  32'(first_err_key), 0);
    check({pfx, "_mism_cnt"},   32'(mism_count), 0);
    check({pfx, "_proto_cnt"},  32'(proto_count), 0);
    check({pfx, "_check_cnt"},  32'(check_count), 0);
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [KB-1:0] k);
    cfg_we = 1; cfg_idx = idx; cfg_key = k; tick(); clr();
  endtask

  initial begin
    clr();
    rst = 1;
    tick(); tick();
    check_zero("reset");
    rst = 0;

    // Insert then lookup one cycle later; correct result returned NP cycles after lookup.
    cfg(0, 8'h12);
    insert = 1; ins_key = 8'h12; ins_value = 8'hA5; tick(); clr();
    lookup = 1; key = 8'h12; tick(); clr();
    tick();
    valid = 1; value = 8'hA5; tick(); clr();
    check("good_mismatch", 32'(mismatch), 0);
    check("good_check_cnt", 32'(check_count), 1);
    check("good_sticky", 32'(err_sticky), 0);

    // Same key, wrong value returned.
    lookup = 1; key = 8'h12; tick(); clr();
    tick();
    valid = 1; value = 8'hA4; tick(); clr();
    check("badval_mismatch", 32'(mismatch), 1);
    check("badval_sticky", 32'(err_sticky), 1);
    check("badval_first_key", 32'(first_err_key), 32'h12);
    check("badval_mism_cnt", 32'(mism_count), 1);
    check("badval_check_cnt", 32'(check_count), 2);
    tick();
    check("badval_pulse_end", 32'(mismatch), 0);
    check("badval_mism_cnt_hold", 32'(mism_count), 1);

    // Lookup and insert of the same key in one cycle: lookup must see absent.
    cfg(0, 8'h12);
    lookup = 1; key = 8'h12; insert = 1; ins_key = 8'h12; ins_value = 8'h33; tick(); clr();
    tick();
    valid = 0; tick(); clr();
    check("same_cyc_absent_ok", 32'(mismatch), 0);
    check("same_cyc_check_cnt", 32'(check_count), 3);
    cfg(0, 8'h12);
    lookup = 1; key = 8'h12; insert = 1; ins_key = 8'h12; ins_value = 8'h33; tick(); clr();
    tick();
    valid = 1; value = 8'h33; tick(); clr();
    check("same_cyc_present_bad", 32'(mismatch), 1);
    check("same_cyc_mism_cnt", 32'(mism_count), 2);
    check("same_cyc_first_key_kept", 32'(first_err_key), 32'h12);
    tick();

    // Duplicate insert while present: protocol error, shadow keeps 0x33.
    insert = 1; ins_key = 8'h12; ins_value = 8'h77; tick(); clr();
    check("dup_proto_err", 32'(proto_err), 1);
    check("dup_proto_cnt", 32'(proto_count), 1);
    lookup = 1; key = 8'h12; tick(); clr();
    check("dup_proto_pulse_end", 32'(proto_err), 0);
    tick();
    valid = 1; value = 8'h33; tick(); clr();
    check("dup_shadow_kept", 32'(mismatch), 0);
    check("dup_check_cnt", 32'(check_count), 5);

    // Insert while busy is ignored without error.
    cfg(1, 8'h34);
    busy = 1; insert = 1; ins_key = 8'h34; ins_value = 8'h11; tick(); clr();
    check("busy_ins_no_err", 32'(proto_err), 0);
    lookup = 1; key = 8'h34; tick(); clr();
    tick();
    valid = 0; tick(); clr();
    check("busy_ins_ignored", 32'(mismatch), 0);
    check("busy_check_cnt", 32'(check_count), 6);

    // Three back-to-back lookups; delete issued alongside the first result.
    lookup = 1; key = 8'h12; tick();
    tick();
    valid = 1; value = 8'h33; modify = 1; del = 1; mod_value = 8'h00; tick(); clr();
    check("del_first_ok", 32'(mismatch), 0);
    check("del_no_proto", 32'(proto_err), 0);
    valid = 1; value = 8'h33; tick(); clr();
    check("del_stale_valid", 32'(mismatch), 1);
    check("del_mism_cnt", 32'(mism_count), 3);
    valid = 0; tick(); clr();
    check("del_third_absent", 32'(mismatch), 0);
    check("del_check_cnt", 32'(check_count), 9);

    // Modify with no lookup in flight.
    tick(); tick();
    modify = 1; mod_value = 8'h55; tick(); clr();
    check("orphan_proto_err", 32'(proto_err), 1);
    check("orphan_proto_cnt", 32'(proto_count), 2);
    check("orphan_no_mismatch", 32'(mismatch), 0);

    // Saturate the checked-lookup counter (slot 0 now deleted, kvs answers absent).
    for (int i = 0; i < (1 << CB) + 5; i++) begin
      lookup = 1; key = 8'h12; valid = 0; tick();
    end
    clr();
    tick(); tick();
    check("sat_check_cnt", 32'(check_count), 32'hFF);
    check("sat_mism_cnt", 32'(mism_count), 3);
    check("sat_proto_cnt", 32'(proto_count), 2);

    // Async reset with a lookup in flight.
    lookup = 1; key = 8'h12; tick(); clr();
    rst = 1; #1;
    check_zero("midrst");
    tick();
    rst = 0;

    // Slots are disabled after reset: no checks happen until reprogrammed.
    lookup = 1; key = 8'h12; tick(); clr();
    tick();
    valid = 1; value = 8'h99; tick(); clr();
    check("post_rst_no_check", 32'(check_count), 0);
    check("post_rst_no_mism", 32'(mismatch), 0);

    // First error after reset is a duplicate insert on slot 2.
    cfg(2, 8'h56);
    insert = 1; ins_key = 8'h56; ins_value = 8'h01; tick(); clr();
    insert = 1; ins_key = 8'h56; ins_value = 8'h02; tick(); clr();
    check("dup2_proto_err", 32'(proto_err), 1);
    check("dup2_sticky", 32'(err_sticky), 1);
    check("dup2_first_key", 32'(first_err_key), 32'h56);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
